// File: rtl/ca3_pkg.sv
// ca3_pkg: shared definitions for the stack CPU datapath slice.
//   WORD_W      default datapath/memory word width
//   STACK_DEPTH default operand stack depth (power of 2, >= 2)
//   op_e        decoded stack operation, used by stack_unit and its bench
//   decode_op   maps raw push/pop/tos strobes to a single op_e value
package ca3_pkg;

  localparam int unsigned WORD_W      = 8;
  localparam int unsigned STACK_DEPTH = 16;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_TOS  = 3'd3,
    OP_REPL = 3'd4
  } op_e;

  // push+pop together means replace-top; tos is ignored whenever push or pop is set
  function automatic op_e decode_op(input logic push, input logic pop, input logic tos);
    if (push && pop) return OP_REPL;
    else if (push)   return OP_PUSH;
    else if (pop)    return OP_POP;
    else if (tos)    return OP_TOS;
    else             return OP_NONE;
  endfunction

endpackage

// File: rtl/stack_unit_if.sv
// stack_unit_if: strobe/data bundle between the controller and the operand stack.
//   push/pop/tos  controller strobes
//   d_in          write data from the MtoS mux
//   d_out         registered read data to the A/B regs
//   count         occupancy 0..DEPTH
//   empty/full    occupancy flags
//   err           sticky illegal-access flag (0 unless STACK_UNIT_ERR_EN)
// Modports: master = controller side, slave = stack side.
interface stack_unit_if
  import ca3_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned DEPTH = STACK_DEPTH
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic             tos;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             err;

  modport master (
    output push, pop, tos, d_in,
    input  d_out, count, empty, full, err
  );

  modport slave (
    input  push, pop, tos, d_in,
    output d_out, count, empty, full, err
  );

endinterface

// File: rtl/stack_regfile.sv
// stack_regfile: DEPTH x WIDTH storage for the operand stack.
//   clk    rising-edge clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  asynchronous read address (top of stack)
//   rdata  asynchronous read data
// Storage is deliberately not reset.
module stack_regfile #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// stack_unit: operand stack for the multicycle stack CPU.
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   sif  stack_unit_if.slave: push/pop/tos/d_in in; d_out/count/empty/full/err out
// Build option: define STACK_UNIT_ERR_EN to get a sticky err flag on illegal
// accesses; otherwise err is tied to 0 and no error register exists.
module stack_unit
  import ca3_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned DEPTH = STACK_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  stack_unit_if.slave    sif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // sp needs CW bits since it reaches DEPTH when full
  logic [CW-1:0]    sp, sp_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] dout_q, dout_nxt;
  logic             empty, full;
  logic             we;
  logic [AW-1:0]    waddr, top_addr;
  logic [WIDTH-1:0] top;
  op_e              op;

  assign op       = decode_op(sif.push, sif.pop, sif.tos);
  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign top_addr = AW'(sp - CW'(1));

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (sif.d_in),
    .raddr (top_addr),
    .rdata (top)
  );

  always_comb begin
    we       = 1'b0;
    waddr    = AW'(sp);
    sp_nxt   = sp;
    cnt_nxt  = cnt;
    dout_nxt = dout_q;
    case (op)
      OP_PUSH: if (!full) begin
        we      = 1'b1;
        sp_nxt  = sp + CW'(1);
        cnt_nxt = cnt + CW'(1);
      end
      OP_POP: if (!empty) begin
        dout_nxt = top;
        sp_nxt   = sp - CW'(1);
        cnt_nxt  = cnt - CW'(1);
      end
      OP_TOS: if (!empty) dout_nxt = top;
      // replace-top: old top goes out while the new word overwrites it
      OP_REPL: if (!empty) begin
        dout_nxt = top;
        we       = 1'b1;
        waddr    = top_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp     <= '0;
      cnt    <= '0;
      dout_q <= '0;
    end else begin
      sp     <= sp_nxt;
      cnt    <= cnt_nxt;
      dout_q <= dout_nxt;
    end
  end

`ifdef STACK_UNIT_ERR_EN
  logic illegal;
  logic err_q;

  assign illegal = ((op == OP_PUSH) && full) ||
                   (((op == OP_POP) || (op == OP_TOS) || (op == OP_REPL)) && empty);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err_q <= 1'b0;
    else if (illegal) err_q <= 1'b1;
  end

  assign sif.err = err_q;
`else
  assign sif.err = 1'b0;
`endif

  assign sif.d_out = dout_q;
  assign sif.count = cnt;
  assign sif.empty = empty;
  assign sif.full  = full;

endmodule

// File: tb/tb_stack_unit.sv
module tb_stack_unit;
  import ca3_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned D = 16;

`ifdef STACK_UNIT_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  stack_unit_if #(.WIDTH(W), .DEPTH(D)) sif ();

  stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // one strobe cycle; returns #1 after the active edge with strobes idle
  task automatic op(input logic p, input logic q, input logic t, input logic [W-1:0] d);
    sif.push = p;
    sif.pop  = q;
    sif.tos  = t;
    sif.d_in = d;
    @(posedge clk);
    #1;
    sif.push = 1'b0;
    sif.pop  = 1'b0;
    sif.tos  = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    sif.push = 1'b0;
    sif.pop  = 1'b0;
    sif.tos  = 1'b0;
    sif.d_in = '0;
    rst      = 1'b0;
    #12;
    check("rst_count", 32'(sif.count), 0);
    check("rst_dout",  32'(sif.d_out), 0);
    check("rst_empty", 32'(sif.empty), 1);
    check("rst_full",  32'(sif.full),  0);
    check("rst_err",   32'(sif.err),   0);
    rst = 1'b1;

    // 1: push three, pop one
    op(1, 0, 0, 8'h11);
    op(1, 0, 0, 8'h22);
    op(1, 0, 0, 8'h33);
    check("t1_count",     32'(sif.count), 3);
    check("t1_empty",     32'(sif.empty), 0);
    check("t1_dout_push", 32'(sif.d_out), 0);
    op(0, 1, 0, 8'h00);
    check("t1_pop",       32'(sif.d_out), 8'h33);
    check("t1_count_pop", 32'(sif.count), 2);

    // 2: tos twice then drain
    op(0, 0, 1, 8'h00);
    check("t2_tos1",   32'(sif.d_out), 8'h22);
    op(0, 0, 1, 8'h00);
    check("t2_tos2",   32'(sif.d_out), 8'h22);
    check("t2_count",  32'(sif.count), 2);
    op(0, 1, 0, 8'h00);
    check("t2_pop1",   32'(sif.d_out), 8'h22);
    op(0, 1, 0, 8'h00);
    check("t2_pop2",   32'(sif.d_out), 8'h11);
    check("t2_empty",  32'(sif.empty), 1);
    check("t2_err",    32'(sif.err),   0);

    // 3: fill, overflow attempt, drain in LIFO order
    for (int i = 0; i < 16; i++) op(1, 0, 0, 8'(i));
    check("t3_full",  32'(sif.full),  1);
    op(1, 0, 0, 8'hAA);
    check("t3_ovf_count", 32'(sif.count), 16);
    check("t3_ovf_full",  32'(sif.full),  1);
    check("t3_ovf_err",   32'(sif.err),   32'(ERR_ON));
    for (int i = 0; i < 16; i++) begin
      op(0, 1, 0, 8'h00);
      check($sformatf("t3_pop%0d", i), 32'(sif.d_out), 32'(15 - i));
    end
    check("t3_empty", 32'(sif.empty), 1);

    // 4: illegal pop/tos on empty keep d_out
    op(1, 0, 0, 8'h5A);
    op(0, 1, 0, 8'h00);
    check("t4_setup", 32'(sif.d_out), 8'h5A);
    op(0, 1, 0, 8'h00);
    check("t4_pop_hold",  32'(sif.d_out), 8'h5A);
    check("t4_pop_count", 32'(sif.count), 0);
    op(0, 0, 1, 8'h00);
    check("t4_tos_hold",  32'(sif.d_out), 8'h5A);
    op(1, 1, 0, 8'hEE);
    check("t4_repl_count", 32'(sif.count), 0);
    check("t4_repl_hold",  32'(sif.d_out), 8'h5A);
    check("t4_err", 32'(sif.err), 32'(ERR_ON));

    // 5: replace top
    op(1, 0, 0, 8'h05);
    op(1, 0, 0, 8'h07);
    op(1, 1, 0, 8'h09);
    check("t5_repl_dout",  32'(sif.d_out), 8'h07);
    check("t5_repl_count", 32'(sif.count), 2);
    op(0, 1, 0, 8'h00);
    check("t5_pop_new", 32'(sif.d_out), 8'h09);
    op(0, 1, 0, 8'h00);
    check("t5_pop_old", 32'(sif.d_out), 8'h05);
    // tos alongside push is ignored
    op(1, 0, 1, 8'h44);
    check("t5_pushtos_count", 32'(sif.count), 1);
    check("t5_pushtos_dout",  32'(sif.d_out), 8'h05);
    op(0, 1, 0, 8'h00);
    check("t5_pushtos_pop",   32'(sif.d_out), 8'h44);

    // 6: async reset mid-cycle
    op(1, 0, 0, 8'h61);
    op(1, 0, 0, 8'h62);
    op(1, 0, 0, 8'h63);
    check("t6_count_pre", 32'(sif.count), 3);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t6_count", 32'(sif.count), 0);
    check("t6_dout",  32'(sif.d_out), 0);
    check("t6_err",   32'(sif.err),   0);
    check("t6_empty", 32'(sif.empty), 1);
    @(negedge clk);
    rst = 1'b1;
    op(1, 0, 0, 8'h66);
    op(0, 1, 0, 8'h00);
    check("t6_after", 32'(sif.d_out), 8'h66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish, expected finish before 50000");
    $fatal(1);
  end

endmodule
